inst_mem_loader: RTL

Serial program loader for the single-cycle CPU's instruction memory. It consumes a byte stream from the UART receiver and assembles little-endian 32-bit words. It writes them into the instruction memory's write port at consecutive word-aligned byte addresses, holding the CPU in reset for the whole load. It is the writer counterpart to the instruction-memory read path, so a new program loads without re-synthesis.

---
 rtl/inst_mem_loader_pkg.sv | 24 ++
 rtl/inst_mem_loader_if.sv | 24 ++
 rtl/inst_mem_loader_word_packer.sv | 40 ++++
 rtl/inst_mem_loader.sv | 132 +++++++++++++
 4 files changed

// File: rtl/inst_mem_loader_pkg.sv
// -----------------------------------------------------------------------------
// loader_pkg
// Shared constants for the serial instruction-memory loader:
//   state_t / S_*     - loader FSM state encodings
//   HDR_BITS          - width of the word-count header
//   BYTES_PER_WORD    - bytes assembled per instruction word
//   TIMEOUT_DEFAULT   - default idle-cycle limit between accepted bytes
// -----------------------------------------------------------------------------
package loader_pkg;

   localparam int unsigned HDR_BITS        = 16;
   localparam int unsigned BYTES_PER_WORD  = 4;
   localparam int unsigned TIMEOUT_DEFAULT = 50_000_000;

   typedef logic [2:0] state_t;

   localparam state_t S_IDLE  = 3'd0;
   localparam state_t S_LEN   = 3'd1;
   localparam state_t S_DATA  = 3'd2;
   localparam state_t S_WRITE = 3'd3;
   localparam state_t S_DONE  = 3'd4;
   localparam state_t S_ERROR = 3'd5;

endpackage

// File: rtl/inst_mem_loader_if.sv
// -----------------------------------------------------------------------------
// inst_mem_loader_if
// Byte-stream input and instruction-memory write port of the loader.
//   rx_data/rx_valid/rx_ready - byte handshake from the UART receiver
//   wr_en/wr_addr/wr_data     - write port of the instruction memory
// Modports: slave  = loader side (consumes bytes, drives the write port)
//           master = environment side (supplies bytes, observes writes)
// -----------------------------------------------------------------------------
interface inst_mem_loader_if;

   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;

   modport slave  (input  rx_data, rx_valid,
                   output rx_ready, wr_en, wr_addr, wr_data);

   modport master (output rx_data, rx_valid,
                   input  rx_ready, wr_en, wr_addr, wr_data);

endinterface

// File: rtl/inst_mem_loader_word_packer.sv
// -----------------------------------------------------------------------------
// loader_word_packer
// Assembles little-endian 32-bit words from accepted bytes.
//   clk, reset  - clock, synchronous active-high reset
//   clear       - restart byte counting at a word boundary
//   accept      - din is consumed this cycle
//   din         - incoming byte
//   word        - assembly register (complete after the 4th byte)
//   last_byte   - the byte accepted this cycle completes a word
// -----------------------------------------------------------------------------
module loader_word_packer
   import loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        accept,
   input  logic [7:0]  din,
   output logic [31:0] word,
   output logic        last_byte
);

   logic [1:0] byte_cnt;

   assign last_byte = accept && (byte_cnt == 2'(BYTES_PER_WORD - 1));

   // Shifting in from the top leaves the first byte in [7:0] after four shifts.
   always_ff @(posedge clk) begin
      if (reset) begin
         byte_cnt <= '0;
         word     <= '0;
      end else if (clear) begin
         byte_cnt <= '0;
      end else if (accept) begin
         byte_cnt <= byte_cnt + 2'd1;
         word     <= {din, word[31:8]};
      end
   end

endmodule

// File: rtl/inst_mem_loader.sv
// -----------------------------------------------------------------------------
// inst_mem_loader
// Loads a program into instruction memory from a UART byte stream:
// 16-bit word count N (low byte first) then N little-endian words, written
// at consecutive word-aligned byte addresses while the CPU is held in reset.
//   clk, reset  - clock, synchronous active-high reset
//   start       - one-cycle pulse that begins a load (ignored while busy)
//   bus         - byte handshake in, instruction-memory write port out
//   cpu_reset   - holds the CPU in reset during a load and after an abort
//   busy        - load in progress
//   done        - last load completed (sticky until next start)
//   error       - last load aborted (sticky until next start)
// -----------------------------------------------------------------------------
module inst_mem_loader
   import loader_pkg::*;
#(
   parameter int unsigned ROM_SIZE       = 1024,
   parameter int unsigned ROM_SIZE_BIT   = 10,
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   inst_mem_loader_if.slave   bus,
   output logic               cpu_reset,
   output logic               busy,
   output logic               done,
   output logic               error
);

   localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   state_t                state;
   logic [ROM_SIZE_BIT:0] word_index;
   logic [HDR_BITS-1:0]   word_count;
   logic                  hdr_hi;
   logic [TW-1:0]         idle_cnt;
   logic [31:0]           wr_addr_q;
   logic [31:0]           packed_word;

   logic                  xfer;
   logic                  word_last;
   logic                  idle_expired;
   logic [HDR_BITS-1:0]   hdr_n;
   logic [HDR_BITS-1:0]   next_idx;

   assign bus.rx_ready = (state == S_LEN) || (state == S_DATA);
   assign xfer         = bus.rx_valid && bus.rx_ready;
   assign hdr_n        = {bus.rx_data, word_count[7:0]};
   assign next_idx     = HDR_BITS'(word_index) + HDR_BITS'(1);
   assign idle_expired = (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

   loader_word_packer u_packer (
      .clk       (clk),
      .reset     (reset),
      .clear     (state == S_LEN),
      .accept    (xfer && (state == S_DATA)),
      .din       (bus.rx_data),
      .word      (packed_word),
      .last_byte (word_last)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         word_index <= '0;
         word_count <= '0;
         hdr_hi     <= 1'b0;
         idle_cnt   <= '0;
         wr_addr_q  <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (start) begin
                  state      <= S_LEN;
                  word_index <= '0;
                  hdr_hi     <= 1'b0;
                  idle_cnt   <= '0;
               end
            end
            S_LEN: begin
               if (xfer) begin
                  idle_cnt <= '0;
                  if (!hdr_hi) begin
                     word_count[7:0] <= bus.rx_data;
                     hdr_hi          <= 1'b1;
                  end else begin
                     word_count <= hdr_n;
                     if ((hdr_n == '0) || (32'(hdr_n) > ROM_SIZE))
                        state <= S_ERROR;
                     else
                        state <= S_DATA;
                  end
               end else if (idle_expired) begin
                  state <= S_ERROR;
               end else begin
                  idle_cnt <= idle_cnt + TW'(1);
               end
            end
            S_DATA: begin
               if (xfer) begin
                  idle_cnt <= '0;
                  if (word_last) begin
                     state     <= S_WRITE;
                     wr_addr_q <= 32'({word_index[ROM_SIZE_BIT-1:0], 2'b00});
                  end
               end else if (idle_expired) begin
                  state <= S_ERROR;
               end else begin
                  idle_cnt <= idle_cnt + TW'(1);
               end
            end
            S_WRITE: begin
               word_index <= next_idx[ROM_SIZE_BIT:0];
               state      <= (next_idx == word_count) ? S_DONE : S_DATA;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Status and write strobe are pure state decodes; wr_data is the packer
   // register, which is complete during the WRITE cycle.
   assign bus.wr_en   = (state == S_WRITE);
   assign bus.wr_addr = wr_addr_q;
   assign bus.wr_data = packed_word;
   assign busy        = (state == S_LEN) || (state == S_DATA) || (state == S_WRITE);
   assign cpu_reset   = busy || (state == S_ERROR);
   assign done        = (state == S_DONE);
   assign error       = (state == S_ERROR);

endmodule
